// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes, FSM encodings and divide-by-zero constants for the mul/div sequencer.
package muldiv_sequencer_pkg;

  localparam int unsigned MD_NB_DATA  = 32;
  localparam int unsigned MD_NB_OP    = 2;
  localparam int unsigned MD_NB_COUNT = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_RUN  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  // Divide by zero: LO is filled with this bit, HI receives the raw dividend.
  localparam logic MD_DIV0_FILL = 1'b1;

  function automatic logic op_is_div(input logic [MD_NB_OP-1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [MD_NB_OP-1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring subtract-shift for divide.
module muldiv_step #(
  parameter int unsigned NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] acc,
  input  logic [NB_DATA-1:0] work,
  input  logic [NB_DATA-1:0] operand,
  input  logic               div_mode,
  output logic [NB_DATA-1:0] acc_next,
  output logic [NB_DATA-1:0] work_next
);

  logic [NB_DATA:0] sum;
  logic [NB_DATA:0] shifted;
  logic [NB_DATA:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (work[0] ? {1'b0, operand} : '0);
    shifted = {acc, work[NB_DATA-1]};
    diff    = shifted - {1'b0, operand};
    if (div_mode) begin
      // Remainder stays below the divisor, so bit NB_DATA of diff is a clean borrow flag.
      if (!diff[NB_DATA]) begin
        acc_next  = diff[NB_DATA-1:0];
        work_next = {work[NB_DATA-2:0], 1'b1};
      end else begin
        acc_next  = shifted[NB_DATA-1:0];
        work_next = {work[NB_DATA-2:0], 1'b0};
      end
    end else begin
      acc_next  = sum[NB_DATA:1];
      work_next = {sum[0], work[NB_DATA-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer holding its own HI/LO pair.
// Define MULDIV_EARLY_TERM_EN to leave RUN early once the remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned NB_DATA  = MD_NB_DATA,
  parameter int unsigned NB_MD_OP = MD_NB_OP,
  parameter int unsigned NB_COUNT = MD_NB_COUNT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_MD_OP-1:0] i_md_op,
  input  logic [NB_DATA-1:0]  i_data_a,
  input  logic [NB_DATA-1:0]  i_data_b,
  input  logic                i_flush,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_DATA-1:0]  o_hi,
  output logic [NB_DATA-1:0]  o_lo
);

  md_state_e             state_q;
  md_state_e             state_d;
  logic [NB_MD_OP-1:0]   op_q;
  logic [NB_DATA-1:0]    a_q;
  logic [NB_DATA-1:0]    b_q;
  logic [NB_DATA-1:0]    acc_q;
  logic [NB_DATA-1:0]    work_q;
  logic [NB_DATA-1:0]    operand_q;
  logic [NB_COUNT-1:0]   count_q;
  logic [NB_DATA-1:0]    hi_q;
  logic [NB_DATA-1:0]    lo_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  accept;
  logic                  is_div;
  logic                  is_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic                  div_zero;
  logic                  early_prep;
  logic                  early_run;
  logic [NB_DATA-1:0]    mag_a;
  logic [NB_DATA-1:0]    mag_b;
  logic [NB_DATA-1:0]    acc_step;
  logic [NB_DATA-1:0]    work_step;
  logic [2*NB_DATA-1:0]  prod_aligned;
  logic [2*NB_DATA-1:0]  prod_final;
  logic [NB_DATA-1:0]    quot_final;
  logic [NB_DATA-1:0]    rem_final;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);
  assign a_neg     = is_signed & a_q[NB_DATA-1];
  assign b_neg     = is_signed & b_q[NB_DATA-1];
  assign mag_a     = a_neg ? -a_q : a_q;
  assign mag_b     = b_neg ? -b_q : b_q;
  assign div_zero  = is_div & (b_q == '0);
  assign accept    = (state_q == MD_IDLE || state_q == MD_DONE) && i_start && !i_flush;

  muldiv_step #(
    .NB_DATA (NB_DATA)
  ) u_step (
    .acc       (acc_q),
    .work      (work_q),
    .operand   (operand_q),
    .div_mode  (is_div),
    .acc_next  (acc_step),
    .work_next (work_step)
  );

`ifdef MULDIV_EARLY_TERM_EN
  // Copy of the multiplier bits not yet consumed by the shift-add loop.
  logic [NB_DATA-1:0] rem_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rem_q <= '0;
    end else if (state_q == MD_PREP) begin
      rem_q <= mag_b;
    end else if (state_q == MD_RUN) begin
      rem_q <= rem_q >> 1;
    end
  end

  assign early_prep = !is_div && (mag_b == '0);
  assign early_run  = !is_div && ((rem_q >> 1) == '0);
`else
  assign early_prep = 1'b0;
  assign early_run  = 1'b0;
`endif

  // Early exit leaves count_q shifts undone; they are applied here in one step.
  assign prod_aligned = {acc_q, work_q} >> count_q;
  assign prod_final   = (a_neg ^ b_neg) ? -prod_aligned : prod_aligned;
  assign quot_final   = (a_neg ^ b_neg) ? -work_q : work_q;
  assign rem_final    = a_neg ? -acc_q : acc_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (i_start && !i_flush) state_d = MD_PREP;
      end
      MD_PREP: begin
        if (i_flush)                       state_d = MD_IDLE;
        else if (div_zero || early_prep)   state_d = MD_FIX;
        else                               state_d = MD_RUN;
      end
      MD_RUN: begin
        if (i_flush)                                       state_d = MD_IDLE;
        else if (count_q == NB_COUNT'(1) || early_run)     state_d = MD_FIX;
      end
      MD_FIX: begin
        if (i_flush) state_d = MD_IDLE;
        else         state_d = MD_DONE;
      end
      MD_DONE: begin
        if (i_start && !i_flush) state_d = MD_PREP;
        else                     state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Datapath, result registers and registered status outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      work_q    <= '0;
      operand_q <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_d == MD_PREP) || (state_d == MD_RUN) || (state_d == MD_FIX);
      done_q <= (state_d == MD_DONE);
      if (accept) begin
        op_q <= i_md_op;
        a_q  <= i_data_a;
        b_q  <= i_data_b;
      end
      case (state_q)
        MD_PREP: begin
          acc_q     <= '0;
          work_q    <= is_div ? mag_a : mag_b;
          operand_q <= is_div ? mag_b : mag_a;
          count_q   <= NB_COUNT'(NB_DATA);
        end
        MD_RUN: begin
          acc_q   <= acc_step;
          work_q  <= work_step;
          count_q <= count_q - NB_COUNT'(1);
        end
        MD_FIX: begin
          if (!i_flush) begin
            if (!is_div) begin
              {hi_q, lo_q} <= prod_final;
            end else if (div_zero) begin
              hi_q <= a_q;
              lo_q <= {NB_DATA{MD_DIV0_FILL}};
            end else begin
              hi_q <= rem_final;
              lo_q <= quot_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: results queued at start, compared when o_done pulses.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [1:0]  i_md_op;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        i_flush;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         sb_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int FLUSH_CYC = 3;
`else
  localparam int FLUSH_CYC = 10;
`endif

  muldiv_sequencer dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_md_op  (i_md_op),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_hi     (o_hi),
    .o_lo     (o_lo)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        q;
    logic [31:0]        r;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        sp = 64'(sa) * 64'(sb);
        return sp;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_TERM_EN
    logic [31:0] mag;
    int          lat;
`endif
    if (op[1]) return (b == 32'd0) ? 3 : 35;
`ifdef MULDIV_EARLY_TERM_EN
    mag = (op == 2'b00 && b[31]) ? -b : b;
    lat = 3;
    for (int i = 0; i < 32; i++) if (mag[i]) lat = 4 + i;
    return lat;
`else
    return 35;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Called at a negedge; returns at the negedge where o_done is seen (or the bound expires).
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input string tag,
                       input int poke);
    int n;
    int busy_bad;
    sb_q.push_back('{hi: ehi, lo: elo, tag: tag});
    last_hi  = ehi;
    last_lo  = elo;
    i_start  = 1'b1;
    i_md_op  = op;
    i_data_a = a;
    i_data_b = b;
    @(negedge i_clk);
    i_start  = 1'b0;
    n        = 1;
    busy_bad = 0;
    while (o_done !== 1'b1 && n < 100) begin
      if (o_busy !== 1'b1) busy_bad++;
      if (n == poke) begin
        i_start  = 1'b1;
        i_md_op  = ~op;
        i_data_a = ~a;
        i_data_b = b + 32'd3;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
      n++;
    end
    i_start = 1'b0;
    check({tag, " busy_while_running"}, 64'(busy_bad), 64'd0);
    check({tag, " latency"}, 64'(n), 64'(exp_latency(op, b)));
    if (o_done === 1'b1) check({tag, " busy_in_done"}, {63'b0, o_busy}, 64'd0);
  endtask

  // Scoreboard consumer: every o_done pulse must match the oldest queued result.
  always @(negedge i_clk) begin
    if (i_reset === 1'b1 && o_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {63'b0, o_done}, 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check({sb_e.tag, " hi"}, {32'b0, o_hi}, {32'b0, sb_e.hi});
        check({sb_e.tag, " lo"}, {32'b0, o_lo}, {32'b0, sb_e.lo});
      end
    end
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    int          n;

    i_reset  = 1'b0;
    i_start  = 1'b0;
    i_md_op  = 2'b00;
    i_data_a = '0;
    i_data_b = '0;
    i_flush  = 1'b0;
    idle(3);
    check("reset busy", {63'b0, o_busy}, 64'd0);
    check("reset done", {63'b0, o_done}, 64'd0);
    check("reset hi", {32'b0, o_hi}, 64'd0);
    check("reset lo", {32'b0, o_lo}, 64'd0);
    i_reset = 1'b1;
    idle(2);

    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
    idle(1);
    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7", 0);
    idle(2);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2", 0);
    idle(1);
    do_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7_restart", 5);
    idle(1);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 0);
    idle(1);
    do_op(MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "divu_by0", 0);
    // Back-to-back: the next start is driven while DONE is showing.
    do_op(MD_MULTU, 32'h1234_5678, 32'd1, 32'h0, 32'h1234_5678, "multu_x1_b2b", 0);
    do_op(MD_DIV, 32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF, "div_by0_b2b", 0);
    idle(1);
    do_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_minsq", 0);
    idle(1);
    do_op(MD_MULT, 32'd1234, 32'd0, 32'h0, 32'h0, "mult_zero", 0);
    idle(1);
    do_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_7_neg2", 0);
    idle(1);

    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 1) ? $urandom : 32'($urandom_range(1, 1000));
      if (i == 4) a = -a;
      r  = model(op, a, b);
      do_op(op, a, b, r[63:32], r[31:0], $sformatf("rand%0d_op%0d", i, op), 0);
      idle(1);
    end

    // Flush mid-operation: no commit, no done, HI/LO keep the previous result.
    i_start  = 1'b1;
    i_md_op  = MD_MULTU;
    i_data_a = 32'd3;
    i_data_b = 32'd4;
    @(negedge i_clk);
    i_start = 1'b0;
    idle(FLUSH_CYC - 1);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush busy_after", {63'b0, o_busy}, 64'd0);
    idle(40);
    check("flush hi_kept", {32'b0, o_hi}, {32'b0, last_hi});
    check("flush lo_kept", {32'b0, o_lo}, {32'b0, last_lo});

    // Start together with flush in IDLE is dropped.
    i_start  = 1'b1;
    i_flush  = 1'b1;
    i_md_op  = MD_DIVU;
    i_data_a = 32'd9;
    i_data_b = 32'd0;
    @(negedge i_clk);
    i_start = 1'b0;
    i_flush = 1'b0;
    check("start_flush busy", {63'b0, o_busy}, 64'd0);
    idle(5);
    check("start_flush lo_kept", {32'b0, o_lo}, {32'b0, last_lo});

    // Asynchronous reset in the middle of an operation clears everything at once.
    i_start  = 1'b1;
    i_md_op  = MD_DIVU;
    i_data_a = 32'd1000;
    i_data_b = 32'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    idle(19);
    #2;
    i_reset = 1'b0;
    #1;
    check("areset busy", {63'b0, o_busy}, 64'd0);
    check("areset done", {63'b0, o_done}, 64'd0);
    check("areset hi", {32'b0, o_hi}, 64'd0);
    check("areset lo", {32'b0, o_lo}, 64'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    idle(2);
    check("post_reset busy", {63'b0, o_busy}, 64'd0);
    do_op(MD_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, "divu_after_reset", 0);
    idle(3);

    n = sb_q.size();
    check("scoreboard_drained", 64'(n), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
